life_key_scan: RTL and testbench

- Input-side counterpart of the LED matrix scanner: drives an X-column by Y-row key/button matrix one column at a time and samples the row sense lines.
- Debounces each key and keeps a debounced key image.
- Emits one (x,y) event per debounced change over a valid/ready handshake to the grid editor, which toggles cells in the life board.
- Sits between the board pins and the grid RAM write logic, alongside the display scanner.

---
 rtl/life_pkg.sv | 15 +
 rtl/life_key_evt_slot.sv | 39 +++
 rtl/life_key_scan.sv | 160 ++++++++++++++++
 tb/tb_life_key_scan.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and default geometry for the life board scanners (display and key matrix).
package life_pkg;

    localparam int unsigned LIFE_X     = 8;
    localparam int unsigned LIFE_Y     = 8;
    localparam int unsigned LIFE_LOG2X = 3;
    localparam int unsigned LIFE_LOG2Y = 3;

    typedef enum logic [1:0] {
        StDrive,
        StSample,
        StCheck
    } scan_state_e;

endpackage

// File: rtl/life_key_evt_slot.sv
// Single-entry valid/ready output register carrying one key event {x, y, press}.
module life_key_evt_slot #(
    parameter int unsigned LOG2X = 3,
    parameter int unsigned LOG2Y = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LOG2X-1:0] load_x,
    input  logic [LOG2Y-1:0] load_y,
    input  logic             load_press,
    input  logic             ready,
    output logic             free,
    output logic             valid,
    output logic [LOG2X-1:0] x,
    output logic [LOG2Y-1:0] y,
    output logic             press
);

    // The slot can take a new event if empty or if its current one leaves this cycle.
    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            x     <= '0;
            y     <= '0;
            press <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            x     <= load_x;
            y     <= load_y;
            press <= load_press;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/life_key_scan.sv
// Key matrix scanner: column drive, row sampling, two-scan debounce and (x,y) event output.
// Optional: define LIFE_KEY_RELEASE_EVT_EN to also report key releases as events.
module life_key_scan
    import life_pkg::*;
#(
    parameter int unsigned X      = LIFE_X,
    parameter int unsigned Y      = LIFE_Y,
    parameter int unsigned LOG2X  = LIFE_LOG2X,
    parameter int unsigned LOG2Y  = LIFE_LOG2Y,
    parameter int unsigned SETTLE = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [X-1:0]       col_drv,
    input  logic [Y-1:0]       sense_row,
    output logic               key_valid,
    input  logic               key_ready,
    output logic [LOG2X-1:0]   key_x,
    output logic [LOG2Y-1:0]   key_y,
    output logic               key_press,
    output logic [X*Y-1:0]     key_map
);

    localparam int unsigned KW = $clog2(X * Y);

`ifdef LIFE_KEY_RELEASE_EVT_EN
    localparam bit ReleaseEvt = 1'b1;
`else
    localparam bit ReleaseEvt = 1'b0;
`endif

    scan_state_e      state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [LOG2X-1:0] col_q, col_d;
    logic [LOG2Y-1:0] row_q, row_d;
    logic [Y-1:0]     samp_q, samp_d;
    logic [X*Y-1:0]   hist_q, hist_d;
    logic [X*Y-1:0]   key_map_d;
    logic [X-1:0]     col_drv_d;

    logic [KW-1:0]    key_idx;
    logic             s, h, d;
    logic             change;
    logic             report;
    logic             advance;
    logic             evt_load;
    logic             slot_free;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        samp_d    = samp_q;
        hist_d    = hist_q;
        key_map_d = key_map;
        col_drv_d = col_drv;
        evt_load  = 1'b0;
        advance   = 1'b0;

        key_idx = KW'(col_q) * KW'(Y) + KW'(row_q);
        s       = samp_q[row_q];
        h       = hist_q[key_idx];
        d       = key_map[key_idx];
        // Debounced change: this scan agrees with the previous one and differs from the image.
        change  = (s == h) && (s != d);
        report  = ReleaseEvt || s;

        unique case (state_q)
            StDrive: begin
                // A zero drive marks the break-before-make cycle of a new column.
                if (col_drv == '0) begin
                    col_drv_d = X'(1) << col_q;
                end else if (cnt_q == 8'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StSample: begin
                samp_d  = sense_row;
                row_d   = '0;
                state_d = StCheck;
            end
            StCheck: begin
                if (change && report) begin
                    if (slot_free) begin
                        evt_load           = 1'b1;
                        key_map_d[key_idx] = s;
                        hist_d[key_idx]    = s;
                        advance            = 1'b1;
                    end
                end else begin
                    hist_d[key_idx] = s;
                    if (change) begin
                        key_map_d[key_idx] = s;
                    end
                    advance = 1'b1;
                end

                if (advance) begin
                    if (row_q == LOG2Y'(Y - 1)) begin
                        row_d     = '0;
                        col_d     = (col_q == LOG2X'(X - 1)) ? '0 : col_q + LOG2X'(1);
                        col_drv_d = '0;
                        cnt_d     = '0;
                        state_d   = StDrive;
                    end else begin
                        row_d = row_q + LOG2Y'(1);
                    end
                end
            end
            default: begin
                state_d = StDrive;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StDrive;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            samp_q  <= '0;
            hist_q  <= '0;
            key_map <= '0;
            col_drv <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            samp_q  <= samp_d;
            hist_q  <= hist_d;
            key_map <= key_map_d;
            col_drv <= col_drv_d;
        end
    end

    life_key_evt_slot #(
        .LOG2X (LOG2X),
        .LOG2Y (LOG2Y)
    ) u_evt_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (evt_load),
        .load_x     (col_q),
        .load_y     (row_q),
        .load_press (s),
        .ready      (key_ready),
        .free       (slot_free),
        .valid      (key_valid),
        .x          (key_x),
        .y          (key_y),
        .press      (key_press)
    );

endmodule

// File: tb/tb_life_key_scan.sv
// Directed bench for life_key_scan with SETTLE=4 on an 8x8 matrix (column period 14 cycles).
module tb_life_key_scan;

    localparam int unsigned X      = 8;
    localparam int unsigned Y      = 8;
    localparam int unsigned LX     = 3;
    localparam int unsigned LY     = 3;
    localparam int unsigned SETTLE = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [X-1:0]    col_drv;
    logic [Y-1:0]    sense_row;
    logic            key_valid;
    logic            key_ready = 1'b1;
    logic [LX-1:0]   key_x;
    logic [LY-1:0]   key_y;
    logic            key_press;
    logic [X*Y-1:0]  key_map;

    logic [X*Y-1:0]  keys_phys = '0;
    int              tests = 0;
    int              fails = 0;
    int              cyc = 0;
    int              vcnt = 0;
    logic [7:0]      evq[$];

    life_key_scan #(
        .X      (X),
        .Y      (Y),
        .LOG2X  (LX),
        .LOG2Y  (LY),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_drv   (col_drv),
        .sense_row (sense_row),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_x     (key_x),
        .key_y     (key_y),
        .key_press (key_press),
        .key_map   (key_map)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key connects its driven column to its row line.
    always_comb begin
        sense_row = '0;
        for (int c = 0; c < int'(X); c++) begin
            if (col_drv[c]) sense_row = sense_row | keys_phys[c*Y +: Y];
        end
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (!rst && key_valid) vcnt <= vcnt + 1;
        if (!rst && key_valid && key_ready) evq.push_back({1'b0, key_press, key_x, key_y});
    end

    function automatic logic [7:0] evt(input logic p, input logic [2:0] x, input logic [2:0] y);
        return {1'b0, p, x, y};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int nq;
        bit seen;

        repeat (3) step();
        check("rst_col_drv", 64'(col_drv), 64'h0);
        check("rst_valid", 64'(key_valid), 64'h0);
        check("rst_x", 64'(key_x), 64'h0);
        check("rst_y", 64'(key_y), 64'h0);
        check("rst_press", 64'(key_press), 64'h0);
        check("rst_map", key_map, 64'h0);
        rst = 1'b0;

        // Column timing: col 0 driven cycles 1..13, break at 14, col 1 from 15.
        wait_until(1);  check("col0_start", 64'(col_drv), 64'h01);
        wait_until(13); check("col0_end", 64'(col_drv), 64'h01);
        wait_until(14); check("col_break", 64'(col_drv), 64'h00);
        wait_until(15); check("col1_start", 64'(col_drv), 64'h02);

        // One-scan glitch on (3,5): sampled in scan 0 only.
        keys_phys[29] = 1'b1;
        wait_until(60);
        keys_phys[29] = 1'b0;
        wait_until(120); check("idle_no_valid", 64'(vcnt), 64'h0);
        wait_until(280);
        check("glitch_no_valid", 64'(vcnt), 64'h0);
        check("glitch_map", key_map, 64'h0);

        // Press (3,5): first sampled in scan 3, reported at row 5 of scan 4 (cycle 502).
        keys_phys[29] = 1'b1;
        wait_until(501); check("press_pre_valid", 64'(key_valid), 64'h0);
        wait_until(502);
        check("press_valid", 64'(key_valid), 64'h1);
        check("press_x", 64'(key_x), 64'h3);
        check("press_y", 64'(key_y), 64'h5);
        check("press_flag", 64'(key_press), 64'h1);
        check("press_map", key_map, 64'h1 << 29);

        // Release (3,5): reported or silently applied at cycle 726.
        wait_until(510);
        keys_phys[29] = 1'b0;
        wait_until(725);
        check("rel_pre_map", key_map, 64'h1 << 29);
        check("press_evq_size", 64'(evq.size()), 64'h1);
        check("press_evq", 64'(evq[0]), 64'(evt(1'b1, 3'd3, 3'd5)));
        wait_until(726);
        check("rel_map", key_map, 64'h0);
`ifdef LIFE_KEY_RELEASE_EVT_EN
        check("rel_valid", 64'(key_valid), 64'h1);
        check("rel_press", 64'(key_press), 64'h0);
        check("rel_y", 64'(key_y), 64'h5);
`else
        check("rel_no_valid", 64'(key_valid), 64'h0);
`endif

        // Three keys in column 2, consumer stalled for 20 cycles after the first event.
        wait_until(730);
        keys_phys[17] = 1'b1;
        keys_phys[20] = 1'b1;
        keys_phys[22] = 1'b1;
`ifdef LIFE_KEY_RELEASE_EVT_EN
        check("rel_evq_size", 64'(evq.size()), 64'h2);
`else
        check("rel_evq_size", 64'(evq.size()), 64'h1);
`endif
        base = evq.size();
        wait_until(900);
        key_ready = 1'b0;
        wait_until(931); check("multi_pre_valid", 64'(key_valid), 64'h0);
        wait_until(932);
        check("multi1_valid", 64'(key_valid), 64'h1);
        check("multi1_x", 64'(key_x), 64'h2);
        check("multi1_y", 64'(key_y), 64'h1);
        wait_until(945);
        check("stall_valid", 64'(key_valid), 64'h1);
        check("stall_y", 64'(key_y), 64'h1);
        check("stall_col", 64'(col_drv), 64'h04);
        check("stall_map", key_map, 64'h1 << 17);
        wait_until(952);
        key_ready = 1'b1;
        wait_until(953);
        check("multi2_valid", 64'(key_valid), 64'h1);
        check("multi2_y", 64'(key_y), 64'h4);
        wait_until(954); check("multi2_drop", 64'(key_valid), 64'h0);
        wait_until(955);
        check("multi3_valid", 64'(key_valid), 64'h1);
        check("multi3_y", 64'(key_y), 64'h6);
        wait_until(956); check("multi3_drop", 64'(key_valid), 64'h0);
        check("multi_evq_size", 64'(evq.size()), 64'(base + 3));
        if (evq.size() >= base + 3) begin
            check("multi_evq0", 64'(evq[base]), 64'(evt(1'b1, 3'd2, 3'd1)));
            check("multi_evq1", 64'(evq[base+1]), 64'(evt(1'b1, 3'd2, 3'd4)));
            check("multi_evq2", 64'(evq[base+2]), 64'(evt(1'b1, 3'd2, 3'd6)));
        end
        check("multi_map", key_map, 64'h52_0000);

        // Reset while an event is pending and unaccepted.
        keys_phys[47] = 1'b1;
        key_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            seen = key_valid;
        end
        check("pend_seen", 64'(seen), 64'h1);
        repeat (3) step();
        check("pend_hold_valid", 64'(key_valid), 64'h1);
        check("pend_hold_x", 64'(key_x), 64'h5);
        check("pend_hold_y", 64'(key_y), 64'h7);
        nq = evq.size();
        rst = 1'b1;
        step();
        check("mid_rst_valid", 64'(key_valid), 64'h0);
        check("mid_rst_map", key_map, 64'h0);
        check("mid_rst_col", 64'(col_drv), 64'h0);
        check("mid_rst_x", 64'(key_x), 64'h0);
        keys_phys = '0;
        rst = 1'b0;
        key_ready = 1'b1;
        step();
        check("restart_col0", 64'(col_drv), 64'h01);
        check("pend_discarded", 64'(evq.size()), 64'(nq));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
